spec_free_list: RTL and testbench

SPEC_FREE_LIST -- requirements
Module: spec_free_list

---
 rtl/spec_free_list_pkg.sv | 10 +
 rtl/SRAM_4R4W_FREELIST.sv | 45 ++++
 rtl/spec_free_list.sv | 118 +++++++++++
 tb/tb_spec_free_list.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spec_free_list_pkg.sv
// Shared rename-stage sizing for the physical-register free list.
package spec_free_list_pkg;

  localparam int unsigned FREE_LIST_SIZE = 32;
  localparam int unsigned FREE_LIST_LOG  = 5;
  localparam int unsigned PHY_REG_LOG    = 6;
  localparam int unsigned ARCH_REG       = 32;
  localparam int unsigned RENAME_WIDTH   = 4;

endpackage : spec_free_list_pkg

// File: rtl/SRAM_4R4W_FREELIST.sv
// Free-list storage: 4 asynchronous read ports, 4 synchronous write ports,
// contents re-initialised to ARCH_REG+i on reset.
module SRAM_4R4W_FREELIST
  import spec_free_list_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 6,
  parameter int unsigned INIT_BASE = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [RENAME_WIDTH*ADDR_W-1:0]   rd_addr_i,
  output logic [RENAME_WIDTH*DATA_W-1:0]   rd_data_o,
  input  logic [RENAME_WIDTH-1:0]          wr_en_i,
  input  logic [RENAME_WIDTH*ADDR_W-1:0]   wr_addr_i,
  input  logic [RENAME_WIDTH*DATA_W-1:0]   wr_data_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Asynchronous reads: writes of this cycle are not bypassed.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
      rd_data_o[k*DATA_W +: DATA_W] = mem_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
    end
  end

  // Reset initialisation and synchronous writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(INIT_BASE + i);
      end
    end else begin
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
        if (wr_en_i[k]) begin
          mem_q[wr_addr_i[k*ADDR_W +: ADDR_W]] <= wr_data_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule : SRAM_4R4W_FREELIST

// File: rtl/spec_free_list.sv
// Circular free list of physical register tags: allocates up to four tags per
// cycle at the head, recycles released tags at the tail, and rewinds the head
// to the architectural head on a flush.
module spec_free_list
  import spec_free_list_pkg::*;
#(
  parameter int unsigned FREE_LIST_SIZE = spec_free_list_pkg::FREE_LIST_SIZE,
  parameter int unsigned FREE_LIST_LOG  = spec_free_list_pkg::FREE_LIST_LOG,
  parameter int unsigned PHY_REG_LOG    = spec_free_list_pkg::PHY_REG_LOG,
  parameter int unsigned ARCH_REG       = spec_free_list_pkg::ARCH_REG
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     renameReady_i,
  input  logic [3:0]               reqVector_i,
  output logic [PHY_REG_LOG-1:0]   freeReg0_o,
  output logic [PHY_REG_LOG-1:0]   freeReg1_o,
  output logic [PHY_REG_LOG-1:0]   freeReg2_o,
  output logic [PHY_REG_LOG-1:0]   freeReg3_o,
  output logic                     stall_o,
  input  logic [3:0]               commitVector_i,
  input  logic [PHY_REG_LOG-1:0]   releaseReg0_i,
  input  logic [PHY_REG_LOG-1:0]   releaseReg1_i,
  input  logic [PHY_REG_LOG-1:0]   releaseReg2_i,
  input  logic [PHY_REG_LOG-1:0]   releaseReg3_i,
  input  logic [2:0]               commitAllocCount_i,
  output logic [FREE_LIST_LOG:0]   freeCount_o
);

  localparam int unsigned PTR_W = FREE_LIST_LOG + 1;
  localparam int unsigned CHK_W = PTR_W + 1;
  localparam int unsigned CNT_W = 3;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] arch_head_q, arch_head_d;
  logic [PTR_W-1:0] free_count_c;
  logic             alloc_c;
  logic [CNT_W-1:0] req_total_c;
  logic [CNT_W-1:0] commit_total_c;

  logic [RENAME_WIDTH*FREE_LIST_LOG-1:0] rd_addr_c;
  logic [RENAME_WIDTH*FREE_LIST_LOG-1:0] wr_addr_c;
  logic [RENAME_WIDTH*PHY_REG_LOG-1:0]   rd_data_c;
  logic [RENAME_WIDTH*PHY_REG_LOG-1:0]   wr_data_c;

  // Occupancy and stall are pure functions of the current pointers.
  always_comb begin
    free_count_c = tail_q - head_q;
    freeCount_o  = free_count_c;
    stall_o      = (free_count_c < PTR_W'(RENAME_WIDTH));
    alloc_c      = renameReady_i & ~stall_o & ~flush_i;
  end

  // Prefix popcounts give each slot its offset from head (reads) or tail (writes).
  always_comb begin
    req_total_c    = '0;
    commit_total_c = '0;
    rd_addr_c      = '0;
    wr_addr_c      = '0;
    for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
      rd_addr_c[k*FREE_LIST_LOG +: FREE_LIST_LOG] = FREE_LIST_LOG'(head_q + PTR_W'(req_total_c));
      wr_addr_c[k*FREE_LIST_LOG +: FREE_LIST_LOG] = FREE_LIST_LOG'(tail_q + PTR_W'(commit_total_c));
      req_total_c    = req_total_c + CNT_W'(reqVector_i[k]);
      commit_total_c = commit_total_c + CNT_W'(commitVector_i[k]);
    end
  end

  // Next-state pointers; flush rewinds head and suppresses allocation.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q + PTR_W'(commit_total_c);
    arch_head_d = arch_head_q + PTR_W'(commitAllocCount_i);
    if (flush_i) begin
      head_d = arch_head_q + PTR_W'(commitAllocCount_i);
    end else if (alloc_c) begin
      head_d = head_q + PTR_W'(req_total_c);
    end
  end

  // Pointer registers with synchronous active-low reset, plus sanity checks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= PTR_W'(FREE_LIST_SIZE);
    end else begin
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      assert (CHK_W'(free_count_c) + CHK_W'(commit_total_c) <= CHK_W'(FREE_LIST_SIZE));
      assert (CHK_W'(commitAllocCount_i) <= CHK_W'(head_q - arch_head_q));
    end
  end

  assign wr_data_c  = {releaseReg3_i, releaseReg2_i, releaseReg1_i, releaseReg0_i};
  assign freeReg0_o = rd_data_c[0*PHY_REG_LOG +: PHY_REG_LOG];
  assign freeReg1_o = rd_data_c[1*PHY_REG_LOG +: PHY_REG_LOG];
  assign freeReg2_o = rd_data_c[2*PHY_REG_LOG +: PHY_REG_LOG];
  assign freeReg3_o = rd_data_c[3*PHY_REG_LOG +: PHY_REG_LOG];

  SRAM_4R4W_FREELIST #(
    .DEPTH     (FREE_LIST_SIZE),
    .ADDR_W    (FREE_LIST_LOG),
    .DATA_W    (PHY_REG_LOG),
    .INIT_BASE (ARCH_REG)
  ) u_sram (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_i (rd_addr_c),
    .rd_data_o (rd_data_c),
    .wr_en_i   (commitVector_i),
    .wr_addr_i (wr_addr_c),
    .wr_data_i (wr_data_c)
  );

endmodule : spec_free_list

// File: tb/tb_spec_free_list.sv
// Directed bench for the rename free list.
module tb_spec_free_list;

  logic       clk;
  logic       reset;
  logic       flush_i;
  logic       renameReady_i;
  logic [3:0] reqVector_i;
  logic [5:0] freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o;
  logic       stall_o;
  logic [3:0] commitVector_i;
  logic [5:0] releaseReg0_i, releaseReg1_i, releaseReg2_i, releaseReg3_i;
  logic [2:0] commitAllocCount_i;
  logic [5:0] freeCount_o;

  int n_checks = 0;
  int n_pass   = 0;

  spec_free_list dut (
    .clk                (clk),
    .reset              (reset),
    .flush_i            (flush_i),
    .renameReady_i      (renameReady_i),
    .reqVector_i        (reqVector_i),
    .freeReg0_o         (freeReg0_o),
    .freeReg1_o         (freeReg1_o),
    .freeReg2_o         (freeReg2_o),
    .freeReg3_o         (freeReg3_o),
    .stall_o            (stall_o),
    .commitVector_i     (commitVector_i),
    .releaseReg0_i      (releaseReg0_i),
    .releaseReg1_i      (releaseReg1_i),
    .releaseReg2_i      (releaseReg2_i),
    .releaseReg3_i      (releaseReg3_i),
    .commitAllocCount_i (commitAllocCount_i),
    .freeCount_o        (freeCount_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic idle();
    flush_i            = 1'b0;
    renameReady_i      = 1'b0;
    reqVector_i        = 4'b0000;
    commitVector_i     = 4'b0000;
    releaseReg0_i      = '0;
    releaseReg1_i      = '0;
    releaseReg2_i      = '0;
    releaseReg3_i      = '0;
    commitAllocCount_i = 3'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("reset_count", 32'(freeCount_o), 32);
    chk("reset_stall", 32'(stall_o), 0);

    // Full-width allocation after reset.
    renameReady_i = 1'b1;
    reqVector_i   = 4'b1111;
    #1;
    chk("alloc4_r0", 32'(freeReg0_o), 32);
    chk("alloc4_r1", 32'(freeReg1_o), 33);
    chk("alloc4_r2", 32'(freeReg2_o), 34);
    chk("alloc4_r3", 32'(freeReg3_o), 35);
    tick();
    idle();
    #1;
    chk("alloc4_count", 32'(freeCount_o), 28);

    // Sparse allocation.
    do_reset();
    renameReady_i = 1'b1;
    reqVector_i   = 4'b1010;
    #1;
    chk("sparse_r1", 32'(freeReg1_o), 32);
    chk("sparse_r3", 32'(freeReg3_o), 33);
    chk("sparse_r2", 32'(freeReg2_o), 33);
    tick();
    idle();
    reqVector_i = 4'b1111;
    #1;
    chk("sparse_count", 32'(freeCount_o), 30);
    chk("sparse_head", 32'(freeReg0_o), 34);

    // Drain to empty, then a stalled request must not move head.
    do_reset();
    renameReady_i = 1'b1;
    reqVector_i   = 4'b1111;
    repeat (7) tick();
    #1;
    chk("drain7_count", 32'(freeCount_o), 4);
    chk("drain7_stall", 32'(stall_o), 0);
    chk("drain7_r0", 32'(freeReg0_o), 60);
    tick();
    #1;
    chk("drain8_count", 32'(freeCount_o), 0);
    chk("drain8_stall", 32'(stall_o), 1);
    tick();
    #1;
    chk("stalled_count", 32'(freeCount_o), 0);
    chk("stalled_r0", 32'(freeReg0_o), 32);

    // Release 7 and 9 into the empty list; no same-cycle bypass.
    idle();
    reqVector_i    = 4'b1111;
    commitVector_i = 4'b0101;
    releaseReg0_i  = 6'd7;
    releaseReg1_i  = 6'd55;
    releaseReg2_i  = 6'd9;
    releaseReg3_i  = 6'd55;
    #1;
    chk("nobypass_r0", 32'(freeReg0_o), 32);
    tick();
    idle();
    #1;
    chk("rel2_count", 32'(freeCount_o), 2);
    chk("rel2_stall", 32'(stall_o), 1);
    commitVector_i = 4'b0011;
    releaseReg0_i  = 6'd11;
    releaseReg1_i  = 6'd13;
    tick();
    idle();
    #1;
    chk("rel4_count", 32'(freeCount_o), 4);
    chk("rel4_stall", 32'(stall_o), 0);
    renameReady_i = 1'b1;
    reqVector_i   = 4'b1111;
    #1;
    chk("wrap_r0", 32'(freeReg0_o), 7);
    chk("wrap_r1", 32'(freeReg1_o), 9);
    chk("wrap_r2", 32'(freeReg2_o), 11);
    chk("wrap_r3", 32'(freeReg3_o), 13);
    tick();
    idle();
    #1;
    chk("wrap_count", 32'(freeCount_o), 0);

    // Allocate 12 while committing 4, then flush back to the arch head.
    do_reset();
    renameReady_i = 1'b1;
    reqVector_i   = 4'b1111;
    tick();
    commitAllocCount_i = 3'd2;
    tick();
    tick();
    idle();
    #1;
    chk("preflush_count", 32'(freeCount_o), 20);
    flush_i       = 1'b1;
    renameReady_i = 1'b1;
    reqVector_i   = 4'b1111;
    tick();
    idle();
    reqVector_i = 4'b1111;
    #1;
    chk("flush_count", 32'(freeCount_o), 28);
    chk("flush_head", 32'(freeReg0_o), 36);

    // Reset during an allocate-plus-release cycle.
    reset          = 1'b0;
    renameReady_i  = 1'b1;
    reqVector_i    = 4'b1111;
    commitVector_i = 4'b1111;
    releaseReg0_i  = 6'd1;
    releaseReg1_i  = 6'd2;
    releaseReg2_i  = 6'd3;
    releaseReg3_i  = 6'd4;
    tick();
    reset = 1'b1;
    idle();
    reqVector_i = 4'b1111;
    #1;
    chk("midrst_count", 32'(freeCount_o), 32);
    chk("midrst_stall", 32'(stall_o), 0);
    chk("midrst_r0", 32'(freeReg0_o), 32);
    chk("midrst_r1", 32'(freeReg1_o), 33);
    chk("midrst_r2", 32'(freeReg2_o), 34);
    chk("midrst_r3", 32'(freeReg3_o), 35);
    renameReady_i = 1'b1;
    reqVector_i   = 4'b0001;
    tick();
    idle();
    #1;
    chk("post_rst_count", 32'(freeCount_o), 31);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_spec_free_list
